// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read master.
//   state_t   : transaction FSM states
//   I2C_READ  : R/W bit value for a read
//   I2C_WRITE : R/W bit value for a write
//   I2C_ACK   : SDA level meaning acknowledge
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    READ,
    SEND_ACK,
    STOP,
    DONE
  } state_t;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_ACK   = 1'b0;

endpackage

// File: rtl/i2c_scl_gen.sv
// Bit-period divider for the I2C master. One bit lasts CLK_DIV clk cycles,
// split into four equal quarters. The counter is held at zero while en=0,
// so every transaction starts exactly at the beginning of a quarter Q0.
//   clk, rst : clock, asynchronous active-high reset
//   en       : run the divider (master busy)
//   q        : current quarter index 0..3
//   tick     : one-cycle pulse on the first clk of every quarter
//   bit_end  : one-cycle pulse on the last clk of the bit period
module i2c_scl_gen #(
  parameter int CLK_DIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] q,
  output logic       tick,
  output logic       bit_end
);

  localparam int QTR = CLK_DIV / 4;
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  logic [QW-1:0] sub;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub <= '0;
      q   <= 2'd0;
    end else if (!en) begin
      sub <= '0;
      q   <= 2'd0;
    end else if (sub == QW'(QTR - 1)) begin
      sub <= '0;
      q   <= q + 2'd1;
    end else begin
      sub <= sub + QW'(1);
    end
  end

  assign tick    = en && (sub == '0);
  assign bit_end = en && (q == 2'd3) && (sub == QW'(QTR - 1));

endmodule

// File: rtl/i2c_master_reader.sv
// I2C read-only bus master. On start it issues START, the 7-bit address with
// R=1, checks the address ACK, reads byte_count bytes (ACKing all but the
// last, which is NACKed) and finishes with STOP.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle request, honoured only when idle
//   slave_addr : target address, latched on start
//   byte_count : number of bytes to read, latched on start
//   scl        : bus clock (1 = released)
//   sda_in     : sampled bus SDA
//   sda_out    : SDA drive (0 = pull low, 1 = release)
//   rx_data    : last received byte
//   rx_valid   : one-cycle strobe, rx_data is new
//   busy       : transaction in progress (START through STOP)
//   done       : one-cycle pulse at the end of a transaction
//   nack_err   : address was not acknowledged; valid with done
module i2c_master_reader
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       slave_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic             scl,
  input  logic             sda_in,
  output logic             sda_out,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err
);

  state_t           state, state_n;
  logic [1:0]       q;
  logic             tick, bit_end;
  logic             q1_tick, q2_tick, q3_tick;
  logic [2:0]       bit_idx;
  logic [6:0]       addr;
  logic [CNT_W-1:0] remaining;
  logic [6:0]       shreg;
  logic             ack_ok;
  logic             sda_q;
  logic [7:0]       tx_byte;

  i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .q       (q),
    .tick    (tick),
    .bit_end (bit_end)
  );

  // SDA may only move at Q0->Q1 (data), Q1->Q2 (START) or Q2->Q3 (STOP).
  assign q1_tick = tick && (q == 2'd1);
  assign q2_tick = tick && (q == 2'd2);
  assign q3_tick = tick && (q == 2'd3);
  assign tx_byte = {addr, I2C_READ};
  assign sda_out = sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    scl     = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = (byte_count == '0) ? DONE : START;
      end
      START: begin
        busy = 1'b1;
        if (bit_end) state_n = ADDR;
      end
      ADDR: begin
        busy = 1'b1;
        scl  = q[1];
        if (bit_end && bit_idx == 3'd7) state_n = ADDR_ACK;
      end
      ADDR_ACK: begin
        busy = 1'b1;
        scl  = q[1];
        if (bit_end) state_n = ack_ok ? READ : STOP;
      end
      READ: begin
        busy = 1'b1;
        scl  = q[1];
        if (bit_end && bit_idx == 3'd7) state_n = SEND_ACK;
      end
      SEND_ACK: begin
        busy = 1'b1;
        scl  = q[1];
        if (bit_end) state_n = (remaining != '0) ? READ : STOP;
      end
      STOP: begin
        busy = 1'b1;
        scl  = q[1];
        if (bit_end) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx   <= 3'd0;
      addr      <= 7'd0;
      remaining <= '0;
      shreg     <= 7'd0;
      ack_ok    <= 1'b0;
      sda_q     <= 1'b1;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      nack_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr      <= slave_addr;
            remaining <= byte_count;
            nack_err  <= 1'b0;
            bit_idx   <= 3'd0;
          end
        end
        START: begin
          if (q2_tick) sda_q <= 1'b0;
        end
        ADDR: begin
          if (q1_tick) sda_q   <= tx_byte[3'd7 - bit_idx];
          if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
        ADDR_ACK: begin
          if (q1_tick) sda_q  <= 1'b1;
          if (q3_tick) ack_ok <= (sda_in == I2C_ACK);
          if (bit_end && !ack_ok) nack_err <= 1'b1;
        end
        READ: begin
          if (q1_tick) sda_q <= 1'b1;
          if (q3_tick) begin
            shreg <= {shreg[5:0], sda_in};
            if (bit_idx == 3'd7) begin
              rx_data  <= {shreg, sda_in};
              rx_valid <= 1'b1;
              // Guarded so a full-scale count can never wrap.
              if (remaining != '0) remaining <= remaining - CNT_W'(1);
            end
          end
          if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
        SEND_ACK: begin
          if (q1_tick) sda_q <= (remaining != '0) ? I2C_ACK : 1'b1;
        end
        STOP: begin
          if (q1_tick) sda_q <= 1'b0;
          if (q3_tick) sda_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
